// File: rtl/layer_scroller.sv
// Vertical-scroll controller for one row of game blocks: steps a pixel offset per
// 1 ms tick until one layer height has scrolled, then latches the next row's map/types.
module layer_scroller #(
  parameter int unsigned N_BLOCKS = 7,
  parameter int unsigned LAYER_H  = 150,
  parameter int unsigned Y_BASE   = 25,
  parameter int unsigned STEP_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                one_ms_tick,
  input  logic                start,
  input  logic                load,
  input  logic [STEP_W-1:0]   speed,
  input  logic [N_BLOCKS-1:0] layer_map_in,
  input  logic [N_BLOCKS-1:0] block_type_in,
  output logic [11:0]         ypos,
  output logic [7:0]          shift_y,
  output logic                busy,
  output logic                done,
  output logic [N_BLOCKS-1:0] layer_map_out,
  output logic [N_BLOCKS-1:0] block_type_out
);

  localparam logic [8:0]  LAYER_H_9 = 9'(LAYER_H);
  localparam logic [7:0]  LAYER_H_8 = 8'(LAYER_H);
  localparam logic [11:0] Y_BASE_12 = 12'(Y_BASE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_END    = 2'd2
  } state_t;

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [8:0]          sum;

  // One bit wider than shift_y so the compare against LAYER_H never sees a wrap.
  assign sum  = {1'b0, shift_y} + 9'(step);
  assign ypos = Y_BASE_12 + 12'(shift_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      shift_y        <= 8'd0;
      step           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      layer_map_out  <= '0;
      block_type_out <= '0;
    end else if (!en) begin
      done <= 1'b0;
    end else begin
      done <= (state == ST_END);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SCROLL;
            busy    <= 1'b1;
            shift_y <= 8'd0;
            step    <= (speed == '0) ? STEP_W'(1) : speed;
          end
        end
        ST_SCROLL: begin
          // Abort wins over a coincident tick: no final increment.
          if (load) begin
            state <= ST_END;
          end else if (one_ms_tick) begin
            if (sum >= LAYER_H_9) begin
              shift_y <= LAYER_H_8;
              state   <= ST_END;
            end else begin
              shift_y <= sum[7:0];
            end
          end
        end
        ST_END: begin
          shift_y        <= 8'd0;
          layer_map_out  <= layer_map_in;
          block_type_out <= block_type_in;
          busy           <= 1'b0;
          state          <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scroller.sv
// Scoreboard bench for layer_scroller: default instance plus a 9-block, LAYER_H=100,
// Y_BASE=475 instance; expected snapshots are queued by stimulus and checked by a monitor.
module tb_layer_scroller;

  logic       clk;
  logic       rst;
  logic       en, tick, start, load;
  logic [2:0] speed;
  logic [6:0] map_in, typ_in, map_out, typ_out;
  logic [11:0] ypos;
  logic [7:0] shift_y;
  logic       busy, done;

  logic       b_en, b_tick, b_start, b_load;
  logic [2:0] b_speed;
  logic [8:0] b_map_in, b_typ_in, b_map_out, b_typ_out;
  logic [11:0] b_ypos;
  logic [7:0] b_shift_y;
  logic       b_busy, b_done;

  layer_scroller u_dut (
    .clk(clk), .rst(rst), .en(en), .one_ms_tick(tick), .start(start), .load(load),
    .speed(speed), .layer_map_in(map_in), .block_type_in(typ_in),
    .ypos(ypos), .shift_y(shift_y), .busy(busy), .done(done),
    .layer_map_out(map_out), .block_type_out(typ_out)
  );

  layer_scroller #(.N_BLOCKS(9), .LAYER_H(100), .Y_BASE(475), .STEP_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .en(b_en), .one_ms_tick(b_tick), .start(b_start), .load(b_load),
    .speed(b_speed), .layer_map_in(b_map_in), .block_type_in(b_typ_in),
    .ypos(b_ypos), .shift_y(b_shift_y), .busy(b_busy), .done(b_done),
    .layer_map_out(b_map_out), .block_type_out(b_typ_out)
  );

  typedef struct {
    int         d;
    logic [7:0] sh;
    logic       bsy;
    logic [8:0] map;
    logic [8:0] typ;
    string      nm;
  } exp_t;

  exp_t obs_q[$];
  exp_t dq0[$];
  exp_t dq1[$];

  int n_checks = 0;
  int n_errors = 0;
  bit stim_fin = 0;

  logic [6:0] cur_map0 = '0, cur_typ0 = '0;
  logic [8:0] cur_map1 = '0, cur_typ1 = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  function void check_item(input exp_t e);
    int base;
    logic [7:0]  a_sh;
    logic        a_b;
    logic [11:0] a_y;
    logic [8:0]  a_m, a_t;
    if (e.d == 0) begin
      base = 25;  a_sh = shift_y;   a_b = busy;   a_y = ypos;
      a_m = {2'b00, map_out}; a_t = {2'b00, typ_out};
    end else begin
      base = 475; a_sh = b_shift_y; a_b = b_busy; a_y = b_ypos;
      a_m = b_map_out; a_t = b_typ_out;
    end
    chk({e.nm, " shift_y"}, int'(a_sh), int'(e.sh));
    chk({e.nm, " busy"}, int'(a_b), int'(e.bsy));
    chk({e.nm, " ypos"}, int'(a_y), base + int'(e.sh));
    chk({e.nm, " map"}, int'(a_m), int'(e.map));
    chk({e.nm, " type"}, int'(a_t), int'(e.typ));
  endfunction

  // Monitor: snapshots at negedge, done pulses matched against queued completions.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) check_item(obs_q.pop_front());
      if (done === 1'b1) begin
        if (dq0.size() == 0) chk("dut0 unexpected done", 1, 0);
        else begin e = dq0.pop_front(); check_item(e); end
      end
      if (b_done === 1'b1) begin
        if (dq1.size() == 0) chk("dut1 unexpected done", 1, 0);
        else begin e = dq1.pop_front(); check_item(e); end
      end
      if (stim_fin) begin
        chk("dut0 missing done", dq0.size(), 0);
        chk("dut1 missing done", dq1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic obs(input int d, input logic [7:0] sh, input logic b, input string nm);
    exp_t e;
    e.d = d; e.sh = sh; e.bsy = b; e.nm = nm;
    e.map = (d == 0) ? {2'b00, cur_map0} : cur_map1;
    e.typ = (d == 0) ? {2'b00, cur_typ0} : cur_typ1;
    obs_q.push_back(e);
  endtask

  task automatic exp_done(input int d, input string nm);
    exp_t e;
    e.d = d; e.sh = 8'd0; e.bsy = 1'b0; e.nm = nm;
    e.map = (d == 0) ? {2'b00, cur_map0} : cur_map1;
    e.typ = (d == 0) ? {2'b00, cur_typ0} : cur_typ1;
    if (d == 0) dq0.push_back(e);
    else        dq1.push_back(e);
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; tick = 0; start = 0; load = 0; speed = 3'd0;
    map_in = '0; typ_in = '0;
    b_en = 1'b1; b_tick = 0; b_start = 0; b_load = 0; b_speed = 3'd0;
    b_map_in = '0; b_typ_in = '0;
    cyc(); cyc();
    obs(0, 8'd0, 1'b0, "reset");
    obs(1, 8'd0, 1'b0, "reset_b");
    rst = 1'b0;
    cyc();

    // Speed 1: full 150-tick scroll.
    map_in = 7'h55; typ_in = 7'h2A; speed = 3'd1; start = 1'b1;
    cyc(); start = 1'b0;
    obs(0, 8'd0, 1'b1, "t1 start");
    for (int i = 1; i <= 150; i++) begin
      pulse_tick();
      obs(0, 8'(i), 1'b1, "t1 tick");
    end
    cur_map0 = 7'h55; cur_typ0 = 7'h2A;
    exp_done(0, "t1 done");
    cyc();
    obs(0, 8'd0, 1'b0, "t1 idle");
    cyc();

    // Speed 4: clamps to 150 on tick 38; shift holds between ticks.
    map_in = 7'h0F; typ_in = 7'h70; speed = 3'd4; start = 1'b1;
    cyc(); start = 1'b0;
    obs(0, 8'd0, 1'b1, "t2 start");
    for (int i = 1; i <= 37; i++) begin
      pulse_tick();
      obs(0, 8'(4 * i), 1'b1, "t2 tick");
      cyc();
      obs(0, 8'(4 * i), 1'b1, "t2 hold");
    end
    pulse_tick();
    obs(0, 8'd150, 1'b1, "t2 clamp");
    cur_map0 = 7'h0F; cur_typ0 = 7'h70;
    exp_done(0, "t2 done");
    cyc();
    obs(0, 8'd0, 1'b0, "t2 idle");
    cyc();

    // Load with coincident tick at 37; map inputs sampled only in END.
    map_in = 7'h7F; typ_in = 7'h7F; speed = 3'd1; start = 1'b1;
    cyc(); start = 1'b0;
    for (int i = 1; i <= 37; i++) pulse_tick();
    obs(0, 8'd37, 1'b1, "t3 at37");
    load = 1'b1; tick = 1'b1;
    cyc(); load = 1'b0; tick = 1'b0;
    obs(0, 8'd37, 1'b1, "t3 load no inc");
    map_in = 7'h33; typ_in = 7'h4C;
    cur_map0 = 7'h33; cur_typ0 = 7'h4C;
    exp_done(0, "t3 done");
    cyc();
    obs(0, 8'd0, 1'b0, "t3 idle");
    cyc();

    // en=0 freezes ticks, load and start mid-scroll.
    speed = 3'd2; start = 1'b1;
    cyc(); start = 1'b0;
    for (int i = 1; i <= 10; i++) pulse_tick();
    obs(0, 8'd20, 1'b1, "t4 pre");
    en = 1'b0; load = 1'b1; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse_tick();
      obs(0, 8'd20, 1'b1, "t4 frozen");
    end
    en = 1'b1; load = 1'b0; start = 1'b0;
    pulse_tick();
    obs(0, 8'd22, 1'b1, "t4 resume");
    load = 1'b1;
    cyc(); load = 1'b0;
    obs(0, 8'd22, 1'b1, "t4 end");
    map_in = 7'h01; typ_in = 7'h40;
    cur_map0 = 7'h01; cur_typ0 = 7'h40;
    exp_done(0, "t4 done");
    cyc();
    obs(0, 8'd0, 1'b0, "t4 idle");
    cyc();

    // Start while busy ignored; restart with speed 0 in the done cycle; reset mid-scroll.
    speed = 3'd3; start = 1'b1;
    cyc(); start = 1'b0;
    for (int i = 1; i <= 3; i++) pulse_tick();
    obs(0, 8'd9, 1'b1, "t5 pre");
    start = 1'b1; speed = 3'd7;
    pulse_tick(); start = 1'b0;
    obs(0, 8'd12, 1'b1, "t5 start ignored");
    pulse_tick();
    obs(0, 8'd15, 1'b1, "t5 step kept");
    load = 1'b1;
    cyc(); load = 1'b0;
    obs(0, 8'd15, 1'b1, "t5 end");
    map_in = 7'h2B; typ_in = 7'h15;
    cur_map0 = 7'h2B; cur_typ0 = 7'h15;
    exp_done(0, "t5 done");
    cyc();
    start = 1'b1; speed = 3'd0;
    cyc(); start = 1'b0;
    obs(0, 8'd0, 1'b1, "t5 restart");
    for (int i = 1; i <= 5; i++) begin
      pulse_tick();
      obs(0, 8'(i), 1'b1, "t5 speed0");
    end
    rst = 1'b1;
    cyc(); rst = 1'b0;
    cur_map0 = '0; cur_typ0 = '0;
    obs(0, 8'd0, 1'b0, "t5 reset");
    cyc();

    // Second instance: 9 blocks, LAYER_H=100, Y_BASE=475.
    b_map_in = 9'h1A5; b_typ_in = 9'h0F3; b_speed = 3'd7; b_start = 1'b1;
    cyc(); b_start = 1'b0;
    obs(1, 8'd0, 1'b1, "t6 start");
    for (int i = 1; i <= 14; i++) begin
      b_tick = 1'b1; cyc(); b_tick = 1'b0;
      obs(1, 8'(7 * i), 1'b1, "t6 tick");
    end
    b_tick = 1'b1; cyc(); b_tick = 1'b0;
    obs(1, 8'd100, 1'b1, "t6 clamp");
    cur_map1 = 9'h1A5; cur_typ1 = 9'h0F3;
    exp_done(1, "t6 done");
    cyc();
    obs(1, 8'd0, 1'b0, "t6 idle");
    cyc(); cyc();
    stim_fin = 1'b1;
  end

endmodule
